// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline, host-burst and data-memory signals around mem_port_arbiter.
// slave = arbiter side, master = pipeline/host/memory side.
interface mem_port_arbiter_if #(
  parameter int vecSize      = 4,
  parameter int dataSize     = 8,
  parameter int registerSize = 16
);
  localparam int W = vecSize * dataSize;

  logic                    pipe_req;
  logic                    pipe_we;
  logic [registerSize-1:0] pipe_addr;
  logic [W-1:0]            pipe_wdata;
  logic                    pipe_stall;

  logic                    host_cmd_valid;
  logic                    host_cmd_ready;
  logic                    host_cmd_we;
  logic [registerSize-1:0] host_cmd_addr;
  logic [7:0]              host_cmd_len;
  logic                    host_wvalid;
  logic                    host_wready;
  logic [W-1:0]            host_wdata;
  logic                    host_rvalid;
  logic                    host_rready;
  logic [W-1:0]            host_rdata;
  logic                    host_done;

  logic                    mem_we;
  logic [registerSize-1:0] mem_addr;
  logic [W-1:0]            mem_wdata;
  logic [W-1:0]            mem_rdata;

  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
    output pipe_stall,
    input  host_cmd_valid, host_cmd_we, host_cmd_addr, host_cmd_len,
    output host_cmd_ready,
    input  host_wvalid, host_wdata,
    output host_wready,
    input  host_rready,
    output host_rvalid, host_rdata, host_done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata,
    input  pipe_stall,
    output host_cmd_valid, host_cmd_we, host_cmd_addr, host_cmd_len,
    input  host_cmd_ready,
    output host_wvalid, host_wdata,
    input  host_wready,
    output host_rready,
    input  host_rvalid, host_rdata, host_done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port vector memory arbiter: pipeline has priority, host bursts sequenced by an FSM.
// Define MEM_ARB_STARVE_GUARD_EN to force the host a slot after STARVE_LIMIT lost cycles.
module mem_port_arbiter #(
  parameter int vecSize      = 4,
  parameter int dataSize     = 8,
  parameter int registerSize = 16
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int W = vecSize * dataSize;
  localparam logic [registerSize-1:0] AddrStep = registerSize'(vecSize);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                  state;
  logic [registerSize-1:0] curAddr;
  logic [7:0]              beatsLeft;
  logic                    inFlight;
  logic                    rvalidQ;
  logic [W-1:0]            rdataQ;
  logic                    doneQ;
  logic                    cmdReadyQ;

  logic hostEligible, forceHost, hostSlot, pipeGrant;
  logic wrBeat, rdIssue, rdHs, cmdHs;

  // A host beat is eligible when it could use the memory this cycle if it won the slot.
  always_comb begin
    hostEligible = 1'b0;
    unique case (state)
      WRITE:   hostEligible = bus.host_wvalid;
      READ:    hostEligible = !inFlight && (beatsLeft != 8'd0) && (!rvalidQ || bus.host_rready);
      default: hostEligible = 1'b0;
    endcase
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  logic [CntW-1:0] starveCnt;

  assign forceHost = hostEligible && (starveCnt == CntW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset)                                          starveCnt <= '0;
    else if (hostEligible && bus.pipe_req && !forceHost) starveCnt <= starveCnt + CntW'(1);
    else                                                starveCnt <= '0;
  end
`else
  assign forceHost = 1'b0;
`endif

  assign hostSlot  = !bus.pipe_req || forceHost;
  assign pipeGrant = bus.pipe_req && !forceHost;
  assign wrBeat    = (state == WRITE) && bus.host_wvalid && hostSlot;
  assign rdIssue   = (state == READ) && hostEligible && hostSlot;
  assign rdHs      = rvalidQ && bus.host_rready;
  assign cmdHs     = cmdReadyQ && bus.host_cmd_valid;

  assign bus.pipe_stall     = bus.pipe_req && !pipeGrant;
  assign bus.host_wready    = (state == WRITE) && hostSlot;
  assign bus.host_cmd_ready = cmdReadyQ;
  assign bus.host_rvalid    = rvalidQ;
  assign bus.host_rdata     = rdataQ;
  assign bus.host_done      = doneQ;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (pipeGrant) begin
      bus.mem_we    = bus.pipe_we;
      bus.mem_addr  = bus.pipe_addr;
      bus.mem_wdata = bus.pipe_wdata;
    end else if (wrBeat) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = curAddr;
      bus.mem_wdata = bus.host_wdata;
    end else if (rdIssue) begin
      bus.mem_addr  = curAddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      curAddr   <= '0;
      beatsLeft <= '0;
      inFlight  <= 1'b0;
      rvalidQ   <= 1'b0;
      rdataQ    <= '0;
      doneQ     <= 1'b0;
      cmdReadyQ <= 1'b1;
    end else begin
      doneQ <= 1'b0;
      // Capture has priority so a same-cycle handshake never drops the new beat.
      if (inFlight) begin
        rdataQ   <= bus.mem_rdata;
        rvalidQ  <= 1'b1;
        inFlight <= 1'b0;
      end else if (rdHs) begin
        rvalidQ  <= 1'b0;
      end

      unique case (state)
        IDLE: if (cmdHs) begin
          curAddr   <= bus.host_cmd_addr;
          beatsLeft <= bus.host_cmd_len;
          cmdReadyQ <= 1'b0;
          if (bus.host_cmd_len == 8'd0) begin
            state <= DONE;
            doneQ <= 1'b1;
          end else begin
            state <= bus.host_cmd_we ? WRITE : READ;
          end
        end
        WRITE: if (wrBeat) begin
          curAddr   <= curAddr + AddrStep;
          beatsLeft <= beatsLeft - 8'd1;
          if (beatsLeft == 8'd1) begin
            state <= DONE;
            doneQ <= 1'b1;
          end
        end
        READ: begin
          if (rdIssue) begin
            inFlight  <= 1'b1;
            curAddr   <= curAddr + AddrStep;
            beatsLeft <= beatsLeft - 8'd1;
          end else if (beatsLeft == 8'd0 && !inFlight && rdHs) begin
            state <= DONE;
            doneQ <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmdReadyQ <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized bursts
// checked against a reference memory image and expected-transaction queues.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.vecSize(4), .dataSize(8), .registerSize(16)) bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data memory: registered read, data valid the cycle after addressing.
  logic [31:0] ram [logic [15:0]];
  logic [31:0] ramRdata = '0;
  assign bus.mem_rdata = ramRdata;
  always @(posedge clk) begin
    logic [31:0] r;
    r = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'h0;
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    ramRdata <= r;
  end

  // Reference: what the host has written, and the transactions it must observe.
  logic [31:0] refMem [logic [15:0]];
  logic [15:0] expWrAddr [$];
  logic [31:0] expWrData [$];
  logic [31:0] expRd [$];
  int          wrCyc [$];
  int          rdCyc [$];
  int          expDone  = 0;
  int          doneCnt  = 0;
  int          doneCyc  = 0;
  int          stallCnt = 0;
  int          cmdCyc   = 0;
  logic [31:0] beatBuf [0:15];

  function automatic logic [31:0] refRd(input logic [15:0] a);
    return refMem.exists(a) ? refMem[a] : 32'h0;
  endfunction

  // Pipeline traffic: 0 idle, 1 random ~30%, 2 continuous. Writes stay in 0x8000-0x80FC.
  int pipeMode = 0;
  initial begin
    bus.pipe_req = 1'b0; bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_wdata = '0;
    forever begin
      step();
      if (pipeMode == 0) begin
        bus.pipe_req = 1'b0; bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_wdata = '0;
      end else begin
        bus.pipe_req   = (pipeMode == 2) || ($urandom_range(9, 0) < 3);
        bus.pipe_we    = 1'($urandom_range(1, 0));
        bus.pipe_addr  = 16'h8000 | 16'($urandom_range(63, 0) * 4);
        bus.pipe_wdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pipe_req && !bus.pipe_stall) begin
        chk("pipe_mirror_addr", bus.mem_addr, bus.pipe_addr);
        chk("pipe_mirror_we", bus.mem_we, bus.pipe_we);
        if (bus.pipe_we) chk("pipe_mirror_wdata", bus.mem_wdata, bus.pipe_wdata);
      end else if (bus.mem_we) begin
        if (expWrAddr.size() == 0) chk("host_wr_unexpected", bus.mem_addr, 16'hDEAD);
        else begin
          chk("host_wr_addr", bus.mem_addr, expWrAddr.pop_front());
          chk("host_wr_data", bus.mem_wdata, expWrData.pop_front());
        end
        wrCyc.push_back(cyc);
      end
`ifndef MEM_ARB_STARVE_GUARD_EN
      if (bus.pipe_req) chk("pipe_stall_strict", bus.pipe_stall, 1'b0);
`endif
      if (bus.host_rvalid && bus.host_rready) begin
        if (expRd.size() == 0) chk("host_rd_unexpected", bus.host_rvalid, 1'b0);
        else chk("host_rd_data", bus.host_rdata, expRd.pop_front());
        rdCyc.push_back(cyc);
      end
      if (bus.host_done) begin
        chk("done_expected", expDone > 0, 1'b1);
        if (expDone > 0) expDone--;
        doneCnt++;
        doneCyc = cyc;
      end
      if (bus.pipe_stall) stallCnt++;
    end
  end

  task automatic sendCmd(input logic we, input logic [15:0] addr, input logic [7:0] len);
    int n = 0;
    bus.host_cmd_valid = 1'b1; bus.host_cmd_we = we;
    bus.host_cmd_addr  = addr; bus.host_cmd_len = len;
    do begin @(negedge clk); n++; end while (!bus.host_cmd_ready && n < 50);
    if (!bus.host_cmd_ready) chk("cmd_ready_timeout", bus.host_cmd_ready, 1'b1);
    step();
    bus.host_cmd_valid = 1'b0;
    cmdCyc = cyc - 1;
  endtask

  task automatic sendBeats(input int first, input int len, input int gapMax);
    int n;
    for (int i = first; i < len; i++) begin
      bus.host_wvalid = 1'b0;
      repeat ($urandom_range(gapMax, 0)) step();
      bus.host_wvalid = 1'b1;
      bus.host_wdata  = beatBuf[i];
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.host_wready && n < 300);
      if (!bus.host_wready) chk("wready_timeout", bus.host_wready, 1'b1);
      step();
    end
    bus.host_wvalid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (doneCnt < target && n < 400) begin step(); n++; end
    if (doneCnt < target) chk("done_timeout", doneCnt, target);
  endtask

  task automatic pushWrites(input logic [15:0] addr, input int len);
    logic [15:0] a;
    for (int i = 0; i < len; i++) begin
      a = addr + 16'(4 * i);
      expWrAddr.push_back(a);
      expWrData.push_back(beatBuf[i]);
      refMem[a] = beatBuf[i];
    end
  endtask

  task automatic hostWrite(input logic [15:0] addr, input int len, input int gapMax);
    int target;
    pushWrites(addr, len);
    expDone++;
    target = doneCnt + 1;
    sendCmd(1'b1, addr, 8'(len));
    sendBeats(0, len, gapMax);
    waitDone(target);
  endtask

  task automatic hostRead(input logic [15:0] addr, input int len, input bit randReady);
    int target;
    int n = 0;
    for (int i = 0; i < len; i++) expRd.push_back(refRd(addr + 16'(4 * i)));
    expDone++;
    target = doneCnt + 1;
    bus.host_rready = randReady ? 1'($urandom_range(1, 0)) : 1'b1;
    sendCmd(1'b0, addr, 8'(len));
    while (doneCnt < target && n < 400) begin
      if (randReady) bus.host_rready = 1'($urandom_range(1, 0));
      step();
      n++;
    end
    if (doneCnt < target) chk("rd_done_timeout", doneCnt, target);
    bus.host_rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int grantK [$];
    int grantStall [$];
    int bi, k, n, target, len, doneBefore;
    bit sawStall, gotW;
    logic [15:0] addr;
    logic [15:0] wrStarts [$];

    reset = 1'b1;
    bus.host_cmd_valid = 1'b0; bus.host_cmd_we = 1'b0; bus.host_cmd_addr = '0; bus.host_cmd_len = '0;
    bus.host_wvalid = 1'b0; bus.host_wdata = '0; bus.host_rready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", bus.host_cmd_ready, 1'b1);
    chk("rst_rvalid", bus.host_rvalid, 1'b0);
    chk("rst_rdata", bus.host_rdata, 32'h0);
    chk("rst_done", bus.host_done, 1'b0);
    chk("rst_wready", bus.host_wready, 1'b0);
    chk("rst_stall", bus.pipe_stall, 1'b0);
    chk("rst_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 49'h0);
    step();

    // Write burst, pipe idle
    beatBuf[0] = 32'h04030201; beatBuf[1] = 32'h08070605; beatBuf[2] = 32'h0C0B0A09;
    wrCyc.delete(); stallCnt = 0;
    hostWrite(16'h0010, 3, 0);
    chk("wr_beats_seen", wrCyc.size(), 3);
    if (wrCyc.size() == 3) begin
      chk("wr_first_access", wrCyc[0], cmdCyc + 1);
      chk("wr_beat1_next", wrCyc[1] - wrCyc[0], 1);
      chk("wr_beat2_next", wrCyc[2] - wrCyc[1], 1);
      chk("wr_done_after_last", doneCyc - wrCyc[2], 1);
    end
    chk("wr_no_stall", stallCnt, 0);

    // Read burst, rready held high: one beat per two cycles, then done
    rdCyc.delete();
    hostRead(16'h0010, 3, 1'b0);
    chk("rd_beats_seen", rdCyc.size(), 3);
    if (rdCyc.size() == 3) begin
      chk("rd_rate_1", rdCyc[1] - rdCyc[0], 2);
      chk("rd_rate_2", rdCyc[2] - rdCyc[1], 2);
      chk("rd_done_after_last", doneCyc - rdCyc[2], 1);
    end

    // Contention: pipeline requests every cycle during a 2-beat write
    pipeMode = 2; step();
    beatBuf[0] = $urandom; beatBuf[1] = $urandom;
    pushWrites(16'h0100, 2);
    expDone++; target = doneCnt + 1;
    sendCmd(1'b1, 16'h0100, 8'd2);
    bus.host_wvalid = 1'b1; bus.host_wdata = beatBuf[0];
    bi = 0; k = 0; sawStall = 1'b0;
    while (bi < 2 && k < 30) begin
      @(negedge clk); k++;
      gotW = bus.host_wready;
      if (gotW) begin grantK.push_back(k); grantStall.push_back(int'(bus.pipe_stall)); end
      sawStall |= bus.pipe_stall;
      step();
      if (gotW) begin bi++; if (bi < 2) bus.host_wdata = beatBuf[bi]; end
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("guard_grants", grantK.size(), 2);
    if (grantK.size() == 2) begin
      chk("guard_first_cycle", grantK[0], 9);
      chk("guard_second_cycle", grantK[1], 18);
      chk("guard_first_stall", grantStall[0], 1);
      chk("guard_second_stall", grantStall[1], 1);
    end
`else
    chk("starve_no_wready", grantK.size(), 0);
    chk("starve_no_stall", sawStall, 1'b0);
`endif
    pipeMode = 0;
    sendBeats(bi, 2, 0);
    waitDone(target);

    // Backpressure: beat 0 held, no second issue while rready low
    expRd.push_back(refRd(16'h0010)); expRd.push_back(refRd(16'h0014));
    expDone++; target = doneCnt + 1;
    bus.host_rready = 1'b0;
    sendCmd(1'b0, 16'h0010, 8'd2);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.host_rvalid && n < 10);
    chk("bp_rvalid_seen", bus.host_rvalid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid_hold", bus.host_rvalid, 1'b1);
      chk("bp_rdata_hold", bus.host_rdata, 32'h04030201);
      chk("bp_no_issue", {bus.mem_we, bus.mem_addr}, 17'h0);
      @(negedge clk);
    end
    step();
    bus.host_rready = 1'b1;
    waitDone(target);
    bus.host_rready = 1'b0;

    // Zero-length command
    expDone++;
    sendCmd(1'b1, 16'h0200, 8'd0);
    @(negedge clk);
    chk("len0_done", bus.host_done, 1'b1);
    chk("len0_no_mem", {bus.mem_we, bus.mem_addr}, 17'h0);
    step(); @(negedge clk);
    chk("len0_done_one_cycle", bus.host_done, 1'b0);
    chk("len0_back_idle", bus.host_cmd_ready, 1'b1);
    step();

    // Address wrap at the top of the map, then read it back
    beatBuf[0] = $urandom; beatBuf[1] = $urandom;
    hostWrite(16'hFFFC, 2, 1);
    hostRead(16'hFFFC, 2, 1'b1);

    // Reset during beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) beatBuf[i] = $urandom;
    expWrAddr.push_back(16'h2000); expWrData.push_back(beatBuf[0]);
    doneBefore = doneCnt;
    sendCmd(1'b1, 16'h2000, 8'd4);
    sendBeats(0, 1, 0);
    bus.host_wvalid = 1'b1; bus.host_wdata = beatBuf[1]; reset = 1'b1;
    step();
    reset = 1'b0; bus.host_wvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_ready", bus.host_cmd_ready, 1'b1);
    chk("rst_mid_wready", bus.host_wready, 1'b0);
    chk("rst_mid_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 49'h0);
    chk("rst_mid_rvalid", bus.host_rvalid, 1'b0);
    chk("rst_mid_done", bus.host_done, 1'b0);
    chk("rst_mid_wr_drained", expWrAddr.size(), 0);
    repeat (3) step();
    chk("rst_mid_no_done_pulse", doneCnt, doneBefore);

    // Randomized bursts with random pipeline contention and host backpressure
    for (int it = 0; it < 30; it++) begin
      pipeMode = int'($urandom_range(1, 0));
      len = int'($urandom_range(6, 0));
      if ($urandom_range(1, 0) == 0 || wrStarts.size() == 0) begin
        addr = 16'($urandom_range(16'h07F8, 0)) << 2;
        for (int i = 0; i < len; i++) beatBuf[i] = $urandom;
        hostWrite(addr, len, 2);
        wrStarts.push_back(addr);
      end else begin
        if ($urandom_range(3, 0) == 0) addr = 16'($urandom_range(16'h07F8, 0)) << 2;
        else addr = wrStarts[$urandom_range(wrStarts.size() - 1, 0)];
        hostRead(addr, len, 1'b1);
      end
      step();
    end
    pipeMode = 0;
    repeat (2) step();

    chk("end_wr_queue_empty", expWrAddr.size(), 0);
    chk("end_rd_queue_empty", expRd.size(), 0);
    chk("end_done_balanced", expDone, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
